reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/rs_pkg.sv | 37 +++
 rtl/rs_wakeup.sv | 22 ++
 rtl/reservation_station.sv | 195 +++++++++++++++++++
 tb/tb_reservation_station.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types for the reservation station: tag/value widths, command layout, entry record.
package rs_pkg;

  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned VAL_W     = 65;
  localparam int unsigned CMD_W     = 10;

  typedef logic [ROB_TAG_W-1:0] rs_tag_t;
  typedef logic [VAL_W-1:0]     rs_val_t;

  // Command bundle, MSB first: memWrite is bit 9, read_enable is bit 0.
  typedef struct packed {
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       need_to_forward;
    logic       left_shift;
    logic       save_cond;
    logic       read_enable;
  } rs_cmd_t;

  typedef struct packed {
    logic    valid;
    rs_tag_t dest_tag;
    rs_tag_t tag1;
    rs_tag_t tag2;
    rs_val_t val1;
    rs_val_t val2;
    rs_cmd_t cmd;
  } rs_entry_t;

  function automatic logic entry_ready(input rs_entry_t e);
    return e.valid && (e.tag1 == '0) && (e.tag2 == '0);
  endfunction

endpackage

// File: rtl/rs_wakeup.sv
// Per-operand wakeup: captures the broadcast value when the waiting tag matches a nonzero CDB tag.
module rs_wakeup
  import rs_pkg::*;
(
  input  logic    cdb_valid_i,
  input  rs_tag_t cdb_tag_i,
  input  rs_val_t cdb_val_i,
  input  rs_tag_t tag_i,
  input  rs_val_t val_i,
  output rs_tag_t next_tag_c,
  output rs_val_t next_val_c
);

  logic hit;

  always_comb begin
    hit        = cdb_valid_i && (cdb_tag_i != '0) && (tag_i == cdb_tag_i);
    next_tag_c = hit ? '0 : tag_i;
    next_val_c = hit ? cdb_val_i : val_i;
  end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: in-order allocation, CDB wakeup, oldest-ready issue.
module reservation_station #(
  parameter int unsigned RS_ENTRIES = 4,
  parameter int unsigned ROB_TAG_W  = rs_pkg::ROB_TAG_W
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       write_en_i,
  input  logic [ROB_TAG_W-1:0]       dest_tag_i,
  input  logic [ROB_TAG_W-1:0]       src1_tag_i,
  input  logic [ROB_TAG_W-1:0]       src2_tag_i,
  input  logic [rs_pkg::VAL_W-1:0]   src1_val_i,
  input  logic [rs_pkg::VAL_W-1:0]   src2_val_i,
  input  logic [rs_pkg::CMD_W-1:0]   cmd_i,
  input  logic                       cdb_valid_i,
  input  logic [ROB_TAG_W-1:0]       cdb_tag_i,
  input  logic [rs_pkg::VAL_W-1:0]   cdb_val_i,
  output logic                       stall_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [ROB_TAG_W-1:0]       issue_dest_tag_o,
  output logic [rs_pkg::VAL_W-1:0]   issue_val1_o,
  output logic [rs_pkg::VAL_W-1:0]   issue_val2_o,
  output logic [rs_pkg::CMD_W-1:0]   issue_cmd_o
);

  import rs_pkg::*;

  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  rs_entry_t        entries_q [RS_ENTRIES];
  rs_entry_t        entries_d [RS_ENTRIES];
  rs_entry_t        woken     [RS_ENTRIES];
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             issue_valid_q, issue_valid_d;
  rs_tag_t          issue_dest_q, issue_dest_d;
  rs_val_t          issue_val1_q, issue_val1_d;
  rs_val_t          issue_val2_q, issue_val2_d;
  rs_cmd_t          issue_cmd_q, issue_cmd_d;

  rs_tag_t          wk_tag1 [RS_ENTRIES];
  rs_tag_t          wk_tag2 [RS_ENTRIES];
  rs_val_t          wk_val1 [RS_ENTRIES];
  rs_val_t          wk_val2 [RS_ENTRIES];
  rs_tag_t          wr_tag1_c, wr_tag2_c;
  rs_val_t          wr_val1_c, wr_val2_c;
  rs_entry_t        wr_entry_c;
  rs_tag_t          cdb_tag_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic             fire_c;

  assign cdb_tag_c = rs_tag_t'(cdb_tag_i);

  // Two operand wakeup units per stored entry.
  for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_wake
    rs_wakeup u_wake1 (
      .cdb_valid_i (cdb_valid_i & entries_q[g].valid),
      .cdb_tag_i   (cdb_tag_c),
      .cdb_val_i   (cdb_val_i),
      .tag_i       (entries_q[g].tag1),
      .val_i       (entries_q[g].val1),
      .next_tag_c  (wk_tag1[g]),
      .next_val_c  (wk_val1[g])
    );
    rs_wakeup u_wake2 (
      .cdb_valid_i (cdb_valid_i & entries_q[g].valid),
      .cdb_tag_i   (cdb_tag_c),
      .cdb_val_i   (cdb_val_i),
      .tag_i       (entries_q[g].tag2),
      .val_i       (entries_q[g].val2),
      .next_tag_c  (wk_tag2[g]),
      .next_val_c  (wk_val2[g])
    );
  end

  // The incoming write sees the same broadcast as the stored entries.
  rs_wakeup u_wr_wake1 (
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_c),
    .cdb_val_i   (cdb_val_i),
    .tag_i       (rs_tag_t'(src1_tag_i)),
    .val_i       (src1_val_i),
    .next_tag_c  (wr_tag1_c),
    .next_val_c  (wr_val1_c)
  );

  rs_wakeup u_wr_wake2 (
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_c),
    .cdb_val_i   (cdb_val_i),
    .tag_i       (rs_tag_t'(src2_tag_i)),
    .val_i       (src2_val_i),
    .next_tag_c  (wr_tag2_c),
    .next_val_c  (wr_val2_c)
  );

  always_comb begin
    wr_entry_c          = '0;
    wr_entry_c.valid    = 1'b1;
    wr_entry_c.dest_tag = rs_tag_t'(dest_tag_i);
    wr_entry_c.tag1     = wr_tag1_c;
    wr_entry_c.tag2     = wr_tag2_c;
    wr_entry_c.val1     = wr_val1_c;
    wr_entry_c.val2     = wr_val2_c;
    wr_entry_c.cmd      = rs_cmd_t'(cmd_i);
  end

  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      woken[i]      = entries_q[i];
      woken[i].tag1 = wk_tag1[i];
      woken[i].tag2 = wk_tag2[i];
      woken[i].val1 = wk_val1[i];
      woken[i].val2 = wk_val2[i];
    end
  end

  // Index of the packet currently presented; the registered valid says whether it exists.
  always_comb begin
    sel_idx_c = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (entry_ready(entries_q[i])) sel_idx_c = IDX_W'(i);
    end
    fire_c = issue_valid_q & issue_ready_i;
  end

  // Collapse on issue, append at the post-collapse tail, then pick the next packet.
  always_comb begin
    logic [CNT_W-1:0] count_mid;
    entries_d     = woken;
    count_mid     = count_q - CNT_W'(fire_c);
    count_d       = count_mid;
    issue_valid_d = 1'b0;
    issue_dest_d  = '0;
    issue_val1_d  = '0;
    issue_val2_d  = '0;
    issue_cmd_d   = '0;

    if (fire_c) begin
      for (int i = 0; i < RS_ENTRIES - 1; i++) begin
        if (IDX_W'(i) >= sel_idx_c) entries_d[i] = woken[i+1];
      end
      entries_d[RS_ENTRIES-1] = '0;
    end

    if (write_en_i && !stall_q) begin
      entries_d[count_mid[IDX_W-1:0]] = wr_entry_c;
      count_d = count_mid + CNT_W'(1);
    end

    stall_d = (count_d == CNT_W'(RS_ENTRIES));

    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (entry_ready(entries_d[i])) begin
        issue_valid_d = 1'b1;
        issue_dest_d  = entries_d[i].dest_tag;
        issue_val1_d  = entries_d[i].val1;
        issue_val2_d  = entries_d[i].val2;
        issue_cmd_d   = entries_d[i].cmd;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_q[i] <= '0;
      count_q       <= '0;
      stall_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_dest_q  <= '0;
      issue_val1_q  <= '0;
      issue_val2_q  <= '0;
      issue_cmd_q   <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) entries_q[i] <= entries_d[i];
      count_q       <= count_d;
      stall_q       <= stall_d;
      issue_valid_q <= issue_valid_d;
      issue_dest_q  <= issue_dest_d;
      issue_val1_q  <= issue_val1_d;
      issue_val2_q  <= issue_val2_d;
      issue_cmd_q   <= issue_cmd_d;
    end
  end

  assign stall_o          = stall_q;
  assign issue_valid_o    = issue_valid_q;
  assign issue_dest_tag_o = ROB_TAG_W'(issue_dest_q);
  assign issue_val1_o     = issue_val1_q;
  assign issue_val2_o     = issue_val2_q;
  assign issue_cmd_o      = issue_cmd_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed and random checks of reservation_station against a queue-based reference model.
module tb_reservation_station;

  localparam int unsigned N = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        write_en_i;
  logic [3:0]  dest_tag_i, src1_tag_i, src2_tag_i;
  logic [64:0] src1_val_i, src2_val_i;
  logic [9:0]  cmd_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [64:0] cdb_val_i;
  logic        stall_o, issue_valid_o, issue_ready_i;
  logic [3:0]  issue_dest_tag_o;
  logic [64:0] issue_val1_o, issue_val2_o;
  logic [9:0]  issue_cmd_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  dest, t1, t2;
    logic [64:0] v1, v2;
    logic [9:0]  cmd;
  } ment_t;

  ment_t q[$];

  reservation_station #(.RS_ENTRIES(N), .ROB_TAG_W(4)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .write_en_i       (write_en_i),
    .dest_tag_i       (dest_tag_i),
    .src1_tag_i       (src1_tag_i),
    .src2_tag_i       (src2_tag_i),
    .src1_val_i       (src1_val_i),
    .src2_val_i       (src2_val_i),
    .cmd_i            (cmd_i),
    .cdb_valid_i      (cdb_valid_i),
    .cdb_tag_i        (cdb_tag_i),
    .cdb_val_i        (cdb_val_i),
    .stall_o          (stall_o),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_dest_tag_o (issue_dest_tag_o),
    .issue_val1_o     (issue_val1_o),
    .issue_val2_o     (issue_val2_o),
    .issue_cmd_o      (issue_cmd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sel();
    for (int i = 0; i < q.size(); i++)
      if (q[i].t1 == 4'd0 && q[i].t2 == 4'd0) return i;
    return -1;
  endfunction

  task automatic check_model();
    int s;
    s = m_sel();
    chk("stall", 80'(stall_o), 80'(q.size() == N));
    chk("issue_valid", 80'(issue_valid_o), 80'(s >= 0));
    if (s >= 0) begin
      chk("issue_dest", 80'(issue_dest_tag_o), 80'(q[s].dest));
      chk("issue_val1", 80'(issue_val1_o), 80'(q[s].v1));
      chk("issue_val2", 80'(issue_val2_o), 80'(q[s].v2));
      chk("issue_cmd", 80'(issue_cmd_o), 80'(q[s].cmd));
    end else begin
      chk("idle_dest", 80'(issue_dest_tag_o), 80'(0));
      chk("idle_val1", 80'(issue_val1_o), 80'(0));
      chk("idle_val2", 80'(issue_val2_o), 80'(0));
      chk("idle_cmd", 80'(issue_cmd_o), 80'(0));
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model, clock.
  task automatic step(input logic wen, input logic [3:0] dest, input logic [3:0] t1,
                      input logic [3:0] t2, input logic [64:0] v1, input logic [64:0] v2,
                      input logic [9:0] cmd, input logic cv, input logic [3:0] ct,
                      input logic [64:0] cval, input logic rdy);
    int    s;
    bit    full;
    ment_t e;
    check_model();
    write_en_i = wen; dest_tag_i = dest; src1_tag_i = t1; src2_tag_i = t2;
    src1_val_i = v1; src2_val_i = v2; cmd_i = cmd;
    cdb_valid_i = cv; cdb_tag_i = ct; cdb_val_i = cval; issue_ready_i = rdy;

    s    = m_sel();
    full = (q.size() == N);
    if (cv && ct != 4'd0) begin
      foreach (q[i]) begin
        if (q[i].t1 == ct) begin q[i].t1 = 4'd0; q[i].v1 = cval; end
        if (q[i].t2 == ct) begin q[i].t2 = 4'd0; q[i].v2 = cval; end
      end
    end
    if (s >= 0 && rdy) q.delete(s);
    if (wen && !full) begin
      e.dest = dest; e.t1 = t1; e.t2 = t2; e.v1 = v1; e.v2 = v2; e.cmd = cmd;
      if (cv && ct != 4'd0 && t1 == ct) begin e.t1 = 4'd0; e.v1 = cval; end
      if (cv && ct != 4'd0 && t2 == ct) begin e.t2 = 4'd0; e.v2 = cval; end
      q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 4'd0, 4'd0, 4'd0, 65'd0, 65'd0, 10'd0, 1'b0, 4'd0, 65'd0, rdy);
  endtask

  task automatic wr(input logic [3:0] dest, input logic [3:0] t1, input logic [3:0] t2,
                    input logic [64:0] v1, input logic [64:0] v2, input logic rdy);
    step(1'b1, dest, t1, t2, v1, v2, 10'(dest) ^ 10'h2A5, 1'b0, 4'd0, 65'd0, rdy);
  endtask

  task automatic cdb(input logic [3:0] ct, input logic [64:0] cval, input logic rdy);
    step(1'b0, 4'd0, 4'd0, 4'd0, 65'd0, 65'd0, 10'd0, 1'b1, ct, cval, rdy);
  endtask

  function automatic logic [3:0] rnd_tag();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
  endfunction

  function automatic logic [64:0] rnd_val();
    return 65'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    reset_i = 1'b1; write_en_i = 1'b0; dest_tag_i = '0; src1_tag_i = '0; src2_tag_i = '0;
    src1_val_i = '0; src2_val_i = '0; cmd_i = '0; cdb_valid_i = 1'b0; cdb_tag_i = '0;
    cdb_val_i = '0; issue_ready_i = 1'b0;
    #1 reset_i = 1'b0;
    #1;
    chk("rst_stall", 80'(stall_o), 80'(0));
    chk("rst_valid", 80'(issue_valid_o), 80'(0));
    chk("rst_dest", 80'(issue_dest_tag_o), 80'(0));
    #1 reset_i = 1'b1;

    // Single ready write issues next cycle, then drains.
    wr(4'd3, 4'd0, 4'd0, 65'd5, 65'd7, 1'b1);
    chk("r035_valid", 80'(issue_valid_o), 80'(1));
    chk("r035_dest", 80'(issue_dest_tag_o), 80'(3));
    chk("r035_val1", 80'(issue_val1_o), 80'(5));
    chk("r035_val2", 80'(issue_val2_o), 80'(7));
    idle(1'b1);
    chk("r035_empty", 80'(issue_valid_o), 80'(0));

    // Wakeup of operand 1 via CDB.
    wr(4'd4, 4'd2, 4'd0, 65'h11, 65'h22, 1'b0);
    idle(1'b0);
    chk("r036_wait", 80'(issue_valid_o), 80'(0));
    cdb(4'd2, 65'h99, 1'b0);
    chk("r036_valid", 80'(issue_valid_o), 80'(1));
    chk("r036_val1", 80'(issue_val1_o), 80'h99);
    chk("r036_dest", 80'(issue_dest_tag_o), 80'(4));
    idle(1'b1);

    // Fill, reject a fifth write, wake the middle entry, keep order of the rest.
    wr(4'd1, 4'd6, 4'd0, 65'h10, 65'h11, 1'b0);
    wr(4'd2, 4'd7, 4'd0, 65'h20, 65'h21, 1'b0);
    wr(4'd3, 4'd0, 4'd8, 65'h30, 65'h31, 1'b0);
    wr(4'd4, 4'd9, 4'd0, 65'h40, 65'h41, 1'b0);
    chk("r037_full", 80'(stall_o), 80'(1));
    wr(4'd5, 4'd0, 4'd0, 65'h50, 65'h51, 1'b1);
    chk("r037_reject", 80'(issue_valid_o), 80'(0));
    cdb(4'd8, 65'h88, 1'b0);
    chk("r037_wake_dest", 80'(issue_dest_tag_o), 80'(3));
    chk("r037_wake_val2", 80'(issue_val2_o), 80'h88);
    idle(1'b1);
    chk("r037_unstall", 80'(stall_o), 80'(0));
    cdb(4'd9, 65'h9, 1'b0);
    cdb(4'd7, 65'h7, 1'b0);
    cdb(4'd6, 65'h6, 1'b0);
    chk("r037_ord0", 80'(issue_dest_tag_o), 80'(1));
    idle(1'b1);
    chk("r037_ord1", 80'(issue_dest_tag_o), 80'(2));
    idle(1'b1);
    chk("r037_ord2", 80'(issue_dest_tag_o), 80'(4));
    idle(1'b1);

    // Same-cycle write and wakeup.
    step(1'b1, 4'd6, 4'd0, 4'd5, 65'h1, 65'h2, 10'h3FF, 1'b1, 4'd5, 65'h55, 1'b0);
    chk("r038_valid", 80'(issue_valid_o), 80'(1));
    chk("r038_val2", 80'(issue_val2_o), 80'h55);
    idle(1'b1);

    // Held packet under backpressure, then oldest-first.
    wr(4'd7, 4'd0, 4'd0, 65'h70, 65'h71, 1'b0);
    wr(4'd8, 4'd3, 4'd0, 65'h80, 65'h81, 1'b0);
    wr(4'd9, 4'd0, 4'd0, 65'h90, 65'h91, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("r039_hold", 80'(issue_dest_tag_o), 80'(7));
    end
    idle(1'b1);
    chk("r039_next", 80'(issue_dest_tag_o), 80'(9));
    cdb(4'd3, 65'h33, 1'b1);
    chk("r039_woken", 80'(issue_dest_tag_o), 80'(8));
    idle(1'b1);

    // Asynchronous reset mid-handshake.
    wr(4'd1, 4'd0, 4'd0, 65'h1, 65'h1, 1'b0);
    wr(4'd2, 4'd0, 4'd0, 65'h2, 65'h2, 1'b0);
    wr(4'd3, 4'd0, 4'd0, 65'h3, 65'h3, 1'b0);
    chk("r040_pre", 80'(issue_valid_o), 80'(1));
    issue_ready_i = 1'b1;
    #2 reset_i = 1'b0;
    #1;
    chk("r040_valid", 80'(issue_valid_o), 80'(0));
    chk("r040_stall", 80'(stall_o), 80'(0));
    chk("r040_dest", 80'(issue_dest_tag_o), 80'(0));
    chk("r040_val1", 80'(issue_val1_o), 80'(0));
    chk("r040_cmd", 80'(issue_cmd_o), 80'(0));
    q.delete();
    #1 reset_i = 1'b1;
    wr(4'hA, 4'd0, 4'd0, 65'hAA, 65'hAB, 1'b0);
    chk("r040_after", 80'(issue_dest_tag_o), 80'hA);
    idle(1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 6), 4'($urandom()), rnd_tag(), rnd_tag(), rnd_val(),
           rnd_val(), 10'($urandom()), ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 6)),
           rnd_val(), ($urandom_range(0, 9) < 5));
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
